mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-outstanding arbiter that shares one memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It accepts requests over valid/ready handshakes, registers the granted request, and drives it onto the memory port. It then routes the memory response back to the owning requester. It sits between the core front/back end and the unified memory interface, and it consumes `dmem_req_ctrl_t` from `core_types_pkg`.

## Interface
- `N_BITS`, default 32: data width.
- `ADDR_W`, default 32: address width.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `if_req_vld  in  1`: IF read request valid.
- `if_req_rdy  out  1`: IF request accepted this cycle when high together with `if_req_vld`.
- `if_req_addr  in  ADDR_W`: fetch address.
- `if_flush  in  1`: discard the response of any IF transaction accepted in an earlier cycle.
- `if_rsp_vld  out  1`: one-cycle pulse carrying the fetch data.
- `if_rsp_data  out  N_BITS`: fetch data.
- `ls_req_vld  in  1`: LS request valid.
- `ls_req_rdy  out  1`: LS request accept.
- `ls_req_addr  in  ADDR_W`: LS address.
- `ls_req_ctrl  in  dmem_req_ctrl_t`: `mtype` selects read (0) or write (1); `len` is the size code, forwarded unchanged; the `vld` field is ignored.
- `ls_req_wdata  in  N_BITS`: store data.
- `ls_rsp_vld  out  1`: one-cycle pulse; load data, or store acknowledge.
- `ls_rsp_data  out  N_BITS`: load data; 0 for stores.
- `mem_req_vld  out  1`: memory request valid.
- `mem_req_rdy  in  1`: memory request accept.
- `mem_req_addr  out  ADDR_W`: memory address.
- `mem_req_we  out  1`: write enable.
- `mem_req_len  out  2`: size code.
- `mem_req_wdata  out  N_BITS`: write data.
- `mem_rsp_vld  in  1`: memory response or write acknowledge.
- `mem_rsp_data  in  N_BITS`: memory read data.
- `err_spurious  out  1`: sticky flag; set by `mem_rsp_vld` outside `WAIT_RSP`; cleared only by reset.

## Operation
- **States:** `IDLE`, `REQ`, `WAIT_RSP`.
- **`IDLE`:**
  - `if_req_rdy` and `ls_req_rdy` are combinational from the request valids and the round-robin pointer `last_ls`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, grant LS when `last_ls`=0, otherwise grant IF. Update `last_ls` on every grant.
  - The grant captures addr, we (IF: 0), len (IF: 2'b10), wdata (IF: 0) and owner into registers. Next state is `REQ`.
  - At most one `rdy` is high in any cycle.
- **`REQ`:**
  - `mem_req_vld`=1; the `mem_req_*` outputs come from the registers and are held stable until `mem_req_rdy`.
  - On handshake, go to `WAIT_RSP`.
  - Both requester `rdy` outputs are 0.
- **`WAIT_RSP`:**
  - On `mem_rsp_vld`, register the data and pulse the owner's `rsp_vld` the next cycle, then go to `IDLE`.
  - Stores return an acknowledge with `ls_rsp_data`=0.
- **Flush:**
  - `if_flush` while an IF-owned transaction is in `REQ` or `WAIT_RSP` sets a `drop` bit.
  - When the response arrives, `if_rsp_vld` is suppressed.
  - `drop` clears on return to `IDLE`.
  - A flush in the same cycle as the `mem_rsp_vld` arrival also drops.
  - A flush in the cycle an IF request is accepted does NOT mark that request.
  - The memory transaction itself is never cancelled.
- **Reset values (asynchronous, whenever `rst_n`=0):**
  - state = `IDLE`; `last_ls` = 1, so IF wins the first tie.
  - `drop` = 0 and `err_spurious` = 0.
  - All `rsp_vld`, `mem_req_vld` and all data/addr outputs are 0.
  - Reset mid-transaction abandons it; no response is ever delivered for it.

## Timing
- An accept at cycle t gives `mem_req_vld` at t+1. With `mem_req_rdy`=1 at t+1 and `mem_rsp_vld` at t+2, the owner's `rsp_vld` fires at t+3.
- Minimum request-to-response latency is 3 cycles.
- The return to `IDLE` happens on the same edge that raises `rsp_vld`, so a new request can be accepted in the `rsp_vld` cycle. Back-to-back throughput is one transaction per 3 cycles.
- `mem_req_rdy` low stalls in `REQ` indefinitely with outputs stable.
- `mem_rsp_vld` in the `REQ` handshake cycle or in `IDLE` is spurious: it sets `err_spurious` and is otherwise ignored.
- `rsp_vld` pulses are exactly one cycle wide. Data holds its value until the next response.

## Test plan
- **Reset and single read:** hold `rst_n` low, then release; IF read to 0x100, memory returns 0xDEADBEEF after 1 cycle. Required: all outputs 0 during reset; `mem_req_vld` at t+1 with addr 0x100, len 2'b10, we=0; `if_rsp_vld` with 0xDEADBEEF at t+3; `ls_rsp_vld` stays 0.
- **Simultaneous requests repeated 4x:** grants alternate IF, LS, IF, LS starting from reset. Each `rsp_vld` reaches the correct owner.
- **LS store with `mem_req_rdy` held low 5 cycles:** `mem_req_addr`, `mem_req_wdata` and `mem_req_we`=1 stay stable for all 5 cycles. `ls_rsp_vld` pulses with data 0 after the acknowledge.
- **Flush cases:**
  - IF read accepted, `if_flush` pulsed in `WAIT_RSP` → no `if_rsp_vld`; the next IF request completes normally.
  - Flush in the accept cycle → response delivered.
- **Spurious response:** `mem_rsp_vld` in `IDLE` → `err_spurious`=1 and stays high; no `rsp_vld` pulse.
- **Reset mid-operation:** assert `rst_n`=0 while in `WAIT_RSP` → state `IDLE` and outputs 0 immediately (asynchronous). A later `mem_rsp_vld` produces no `rsp_vld` and sets `err_spurious`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IF/LS arbiter onto one memory port

package core_types_pkg;
    typedef struct packed {
        logic       vld;
        logic       mtype;
        logic [1:0] len;
    } dmem_req_ctrl_t;
endpackage

module mem_port_arbiter
    import core_types_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req_vld,
    output logic                 if_req_rdy,
    input  logic [ADDR_W-1:0]    if_req_addr,
    input  logic                 if_flush,
    output logic                 if_rsp_vld,
    output logic [N_BITS-1:0]    if_rsp_data,
    input  logic                 ls_req_vld,
    output logic                 ls_req_rdy,
    input  logic [ADDR_W-1:0]    ls_req_addr,
    input  dmem_req_ctrl_t       ls_req_ctrl,
    input  logic [N_BITS-1:0]    ls_req_wdata,
    output logic                 ls_rsp_vld,
    output logic [N_BITS-1:0]    ls_rsp_data,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic                 mem_req_we,
    output logic [1:0]           mem_req_len,
    output logic [N_BITS-1:0]    mem_req_wdata,
    input  logic                 mem_rsp_vld,
    input  logic [N_BITS-1:0]    mem_rsp_data,
    output logic                 err_spurious
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    state_t state_q, state_d;
    logic   last_ls_q;
    logic   owner_ls_q;
    logic   drop_q;
    logic   grant_if, grant_ls;
    logic   rsp_fire;
    logic   unused_ctrl_vld;

    assign unused_ctrl_vld = ls_req_ctrl.vld;

    // LS wins a tie only when IF was granted last (last_ls_q low)
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (ls_req_vld && (!if_req_vld || !last_ls_q)) begin
                    grant_ls = 1'b1;
                end else if (if_req_vld) begin
                    grant_if = 1'b1;
                end
                if (grant_if || grant_ls) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_rdy) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_req_rdy  = grant_if;
    assign ls_req_rdy  = grant_ls;
    assign mem_req_vld = (state_q == REQ);
    assign rsp_fire    = (state_q == WAIT_RSP) && mem_rsp_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_ls_q     <= 1'b1;
            owner_ls_q    <= 1'b0;
            drop_q        <= 1'b0;
            err_spurious  <= 1'b0;
            if_rsp_vld    <= 1'b0;
            if_rsp_data   <= '0;
            ls_rsp_vld    <= 1'b0;
            ls_rsp_data   <= '0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_len   <= 2'b00;
            mem_req_wdata <= '0;
        end else begin
            state_q    <= state_d;
            if_rsp_vld <= 1'b0;
            ls_rsp_vld <= 1'b0;

            if (grant_if || grant_ls) begin
                last_ls_q     <= grant_ls;
                owner_ls_q    <= grant_ls;
                mem_req_addr  <= grant_ls ? ls_req_addr : if_req_addr;
                mem_req_we    <= grant_ls & ls_req_ctrl.mtype;
                mem_req_len   <= grant_ls ? ls_req_ctrl.len : 2'b10;
                mem_req_wdata <= grant_ls ? ls_req_wdata : '0;
            end

            if (mem_rsp_vld && (state_q != WAIT_RSP)) begin
                err_spurious <= 1'b1;
            end

            // a flush arriving with the response drops it just like an earlier one
            if (rsp_fire) begin
                drop_q <= 1'b0;
                if (owner_ls_q) begin
                    ls_rsp_vld  <= 1'b1;
                    ls_rsp_data <= mem_req_we ? '0 : mem_rsp_data;
                end else if (!drop_q && !if_flush) begin
                    if_rsp_vld  <= 1'b1;
                    if_rsp_data <= mem_rsp_data;
                end
            end else if (if_flush && (state_q != IDLE) && !owner_ls_q) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;
    import core_types_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           if_req_vld, if_req_rdy, if_flush, if_rsp_vld;
    logic [31:0]    if_req_addr, if_rsp_data;
    logic           ls_req_vld, ls_req_rdy, ls_rsp_vld;
    logic [31:0]    ls_req_addr, ls_req_wdata, ls_rsp_data;
    dmem_req_ctrl_t ls_req_ctrl;
    logic           mem_req_vld, mem_req_rdy, mem_req_we, mem_rsp_vld, err_spurious;
    logic [31:0]    mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [1:0]     mem_req_len;

    mem_port_arbiter #(.N_BITS(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_vld(if_req_vld), .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_vld(if_rsp_vld), .if_rsp_data(if_rsp_data),
        .ls_req_vld(ls_req_vld), .ls_req_rdy(ls_req_rdy), .ls_req_addr(ls_req_addr),
        .ls_req_ctrl(ls_req_ctrl), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_vld(ls_rsp_vld), .ls_rsp_data(ls_rsp_data),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_len(mem_req_len), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // reference state: round-robin memory of who was served, sticky error, held data, memory image
    bit          m_last_ls;
    bit          exp_err;
    logic [31:0] exp_if_data, exp_ls_data;
    logic [31:0] mem_m [logic [31:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : ~a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_vld = 0; if_req_addr = 0; if_flush = 0;
        ls_req_vld = 0; ls_req_addr = 0; ls_req_ctrl = '0; ls_req_wdata = 0;
        mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rdy"}, {if_req_rdy, ls_req_rdy}, 0);
        chk({tag, " rsp_vld"}, {if_rsp_vld, ls_rsp_vld}, 0);
        chk({tag, " rsp_data"}, {if_rsp_data, ls_rsp_data}, 0);
        chk({tag, " mem_ctl"}, {mem_req_vld, mem_req_we, mem_req_len, err_spurious}, 0);
        chk({tag, " mem_addr_wdata"}, {mem_req_addr, mem_req_wdata}, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        chk_all_zero("reset held");
        rst_n = 1;
        m_last_ls = 1; exp_err = 0; exp_if_data = 0; exp_ls_data = 0;
    endtask

    task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                          input bit lw, input logic [1:0] llen, input logic [31:0] lwd,
                          input int stall, input int dly, input int fmode_in);
        bit          win_ls, drop;
        bit          e_we;
        int          fmode;
        logic [1:0]  e_len;
        logic [31:0] e_addr, e_wd, rv;
        fmode  = (fmode_in == 3 && dly == 0) ? 4 : fmode_in;
        win_ls = (iv && lv) ? !m_last_ls : lv;
        m_last_ls = win_ls;
        e_addr = win_ls ? la : ia;
        e_we   = win_ls && lw;
        e_len  = win_ls ? llen : 2'b10;
        e_wd   = win_ls ? lwd : 32'd0;
        drop   = !win_ls && (fmode >= 2);

        if_req_vld = iv; if_req_addr = ia;
        ls_req_vld = lv; ls_req_addr = la; ls_req_wdata = lwd;
        ls_req_ctrl = '{vld: 1'($urandom_range(0, 1)), mtype: lw, len: llen};
        if_flush = (fmode == 1);
        mem_req_rdy = 1'($urandom_range(0, 1));
        mem_rsp_vld = 0; mem_rsp_data = $urandom;
        #1;
        chk("if_req_rdy grant", if_req_rdy, !win_ls);
        chk("ls_req_rdy grant", ls_req_rdy, win_ls);
        step();
        chk("rsp_vld one cycle", {if_rsp_vld, ls_rsp_vld}, 0);
        chk("if_rsp_data hold", if_rsp_data, exp_if_data);
        chk("ls_rsp_data hold", ls_rsp_data, exp_ls_data);

        for (int s = 0; s <= stall; s++) begin
            if_flush = (fmode == 2 && s == 0);
            mem_req_rdy = (s == stall);
            #1;
            chk("mem_req_vld in REQ", mem_req_vld, 1);
            chk("mem_req_addr", mem_req_addr, e_addr);
            chk("mem_req_we_len", {mem_req_we, mem_req_len}, {e_we, e_len});
            chk("mem_req_wdata", mem_req_wdata, e_wd);
            chk("rdy low in REQ", {if_req_rdy, ls_req_rdy}, 0);
            step();
        end
        mem_req_rdy = 0; if_flush = 0;

        for (int w = 0; w < dly; w++) begin
            if_flush = (fmode == 3 && w == 0);
            mem_rsp_data = $urandom;
            #1;
            chk("mem_req_vld in WAIT", mem_req_vld, 0);
            chk("rdy low in WAIT", {if_req_rdy, ls_req_rdy}, 0);
            chk("no early rsp_vld", {if_rsp_vld, ls_rsp_vld}, 0);
            step();
        end

        rv = mem_rd(e_addr);
        if (e_we) mem_m[e_addr] = lwd;
        mem_rsp_vld = 1;
        mem_rsp_data = e_we ? $urandom : rv;
        if_flush = (fmode == 4);
        step();
        mem_rsp_vld = 0; if_flush = 0; if_req_vld = 0; ls_req_vld = 0;

        if (win_ls) begin
            exp_ls_data = e_we ? 32'd0 : rv;
            chk("ls_rsp_vld pulse", {if_rsp_vld, ls_rsp_vld}, 2'b01);
        end else begin
            if (!drop) exp_if_data = rv;
            chk("if_rsp_vld pulse", {if_rsp_vld, ls_rsp_vld}, {!drop, 1'b0});
        end
        chk("if_rsp_data", if_rsp_data, exp_if_data);
        chk("ls_rsp_data", ls_rsp_data, exp_ls_data);
        chk("err_spurious", err_spurious, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          iv, lv;
        logic [1:0]  sel;
        logic [31:0] ia, la;

        do_reset();
        mem_m[32'h100] = 32'hDEADBEEF;
        do_txn(1, 0, 32'h100, 32'h0, 0, 2'b00, 32'h0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 32'h200 + 32'(i * 4), 32'h300 + 32'(i * 4), 1'(i >> 1), 2'(i), $urandom, 0, 1, 0);

        do_txn(0, 1, 32'h0, 32'h40, 1, 2'b10, 32'hA5A5_1234, 5, 2, 0);
        do_txn(0, 1, 32'h0, 32'h40, 0, 2'b10, 32'h0, 0, 0, 0);

        do_txn(1, 0, 32'h40, 32'h0, 0, 2'b10, 32'h0, 0, 2, 3);
        do_txn(1, 0, 32'h44, 32'h0, 0, 2'b10, 32'h0, 0, 0, 0);
        do_txn(1, 0, 32'h48, 32'h0, 0, 2'b10, 32'h0, 1, 1, 1);
        do_txn(1, 0, 32'h4C, 32'h0, 0, 2'b10, 32'h0, 0, 1, 4);
        do_txn(0, 1, 32'h0, 32'h50, 0, 2'b01, 32'h0, 0, 2, 3);

        mem_rsp_vld = 1; mem_rsp_data = 32'hBAD0_BAD0;
        step();
        mem_rsp_vld = 0;
        exp_err = 1;
        chk("spurious in IDLE sets err", err_spurious, 1);
        chk("spurious no rsp_vld", {if_rsp_vld, ls_rsp_vld}, 0);
        step();
        chk("err_spurious sticky", err_spurious, 1);

        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(1, 3));
            iv = sel[0]; lv = sel[1];
            ia = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            la = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            do_txn(iv, lv, ia, la, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        if_req_vld = 1; if_req_addr = 32'h80;
        step();
        if_req_vld = 0; mem_req_rdy = 1;
        step();
        mem_req_rdy = 0;
        rst_n = 0;
        #1;
        chk_all_zero("async reset mid-op");
        step();
        rst_n = 1;
        m_last_ls = 1; exp_err = 0; exp_if_data = 0; exp_ls_data = 0;
        mem_rsp_vld = 1; mem_rsp_data = 32'h1234_5678;
        step();
        mem_rsp_vld = 0;
        chk("late rsp after reset no rsp_vld", {if_rsp_vld, ls_rsp_vld}, 0);
        chk("late rsp after reset err", err_spurious, 1);
        exp_err = 1;
        do_txn(1, 1, 32'h10, 32'h14, 0, 2'b00, 32'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
